// File: rtl/miss_refill_pkg.sv
// Shared types and constants for the cache-miss refill engine.
// Width macros fall back to local defaults when the build does not supply them.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef INDEX_WIDTH
`define INDEX_WIDTH 7
`endif
`ifndef OFFSET_WIDTH
`define OFFSET_WIDTH 9
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif

package miss_refill_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    function automatic int fill_width(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/miss_refill.sv
// Single-outstanding cache-miss refill: one-beat AXI read, then one fill FIFO write.
// Optional R-wait watchdog enabled by defining MISS_REFILL_TIMEOUT_EN.
module miss_refill
    import miss_refill_pkg::*;
#(
    parameter int ADDR_WIDTH     = `AXI_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `AXI_DATA_WIDTH,
    parameter int INDEX_WIDTH    = `INDEX_WIDTH,
    parameter int OFFSET_WIDTH   = `OFFSET_WIDTH,
    parameter int ID_WIDTH       = `AXI_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID = `AXI_ID,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int FILL_W        = fill_width(ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    output logic [ID_WIDTH-1:0]   arid_o,
    output logic                  arvalid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    input  logic                  arready_i,
    input  logic [ID_WIDTH-1:0]   rid_i,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    output logic                  rready_o,
    input  logic                  afull_i,
    output logic                  wren_o,
    output logic [FILL_W-1:0]     data_o,
    output logic                  resp_valid_o,
    output logic                  resp_err_o
);

    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_WIDTH;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  r_hs;
    logic                  r_timeout;

    // rid is not checked; the index field is carried inside the line address.
    logic [ID_WIDTH-1:0]    unused_rid;
    logic [INDEX_WIDTH-1:0] unused_index;
    assign unused_rid   = rid_i;
    assign unused_index = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];

    assign arid_o    = ID;
    assign arlen_o   = 8'd0;
    assign arsize_o  = 3'($clog2(DATA_WIDTH / 8));
    assign arburst_o = AXI_BURST_INCR;

    assign miss_ready_o = (state_q == S_IDLE);
    assign arvalid_o    = (state_q == S_AR);
    assign araddr_o     = addr_q;
    assign resp_valid_o = (state_q == S_DONE);
    assign resp_err_o   = (state_q == S_DONE) && err_q;
    assign wren_o       = (state_q == S_DONE) && !err_q;
    assign data_o       = {addr_q, rdata_q};
    assign r_hs         = (state_q == S_R) && rvalid_i && rready_o;

`ifdef MISS_REFILL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Stray beats after a timeout are drained while idle.
    assign rready_o  = ((state_q == S_R) && !afull_i) || (state_q == S_IDLE);
    assign r_timeout = (state_q == S_R) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_d     = (state_q == S_R) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign rready_o       = (state_q == S_R) && !afull_i;
    assign r_timeout      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_valid_i) begin
                        addr_q  <= miss_addr_i & LINE_MASK;
                        state_q <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready_i) state_q <= S_R;
                end
                S_R: begin
                    if (r_hs) begin
                        rdata_q <= rdata_i;
                        err_q   <= (rresp_i != AXI_RESP_OKAY) || !rlast_i;
                        state_q <= S_DONE;
                    end else if (r_timeout) begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_miss_refill.sv
// Randomized and directed bench for miss_refill with an arithmetic reference of each transaction.
module tb_miss_refill;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int OW = 9;
    localparam int IW = 4;
    localparam logic [IW-1:0] TB_ID = 4'h5;
    localparam int TO = 16;
`ifdef MISS_REFILL_TIMEOUT_EN
    localparam logic IDLE_RREADY = 1'b1;
`else
    localparam logic IDLE_RREADY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          miss_valid_i = 1'b0;
    logic          miss_ready_o;
    logic [AW-1:0] miss_addr_i = '0;
    logic [IW-1:0] arid_o;
    logic          arvalid_o;
    logic [AW-1:0] araddr_o;
    logic [7:0]    arlen_o;
    logic [2:0]    arsize_o;
    logic [1:0]    arburst_o;
    logic          arready_i = 1'b0;
    logic [IW-1:0] rid_i = '0;
    logic          rvalid_i = 1'b0;
    logic [DW-1:0] rdata_i = '0;
    logic [1:0]    rresp_i = 2'b00;
    logic          rlast_i = 1'b1;
    logic          rready_o;
    logic          afull_i = 1'b0;
    logic          wren_o;
    logic [AW+DW-1:0] data_o;
    logic          resp_valid_o;
    logic          resp_err_o;

    int checks = 0;
    int errors = 0;
    int wren_cnt = 0;

    miss_refill #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INDEX_WIDTH(7), .OFFSET_WIDTH(OW),
        .ID_WIDTH(IW), .ID(TB_ID), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
        .arid_o(arid_o), .arvalid_o(arvalid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o), .arready_i(arready_i),
        .rid_i(rid_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rready_o(rready_o),
        .afull_i(afull_i), .wren_o(wren_o), .data_o(data_o),
        .resp_valid_o(resp_valid_o), .resp_err_o(resp_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wren_o === 1'b1) wren_cnt = wren_cnt + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"}, miss_ready_o, 1);
        check({tag, "_arvalid"}, arvalid_o, 0);
        check({tag, "_rready"}, rready_o, IDLE_RREADY);
        check({tag, "_wren"}, wren_o, 0);
        check({tag, "_resp_valid"}, resp_valid_o, 0);
        check({tag, "_resp_err"}, resp_err_o, 0);
        check({tag, "_araddr"}, araddr_o, 0);
        check({tag, "_data"}, data_o, 0);
    endtask

    // Accept a miss and advance to the first R-wait cycle with AR accepted after ar_dly stalls.
    task automatic issue_miss(input logic [AW-1:0] a, input int ar_dly);
        logic [AW-1:0] line;
        line = (a >> OW) << OW;
        check("idle_ready", miss_ready_o, 1);
        miss_valid_i = 1'b1;
        miss_addr_i  = a;
        @(posedge clk);
        @(negedge clk);
        miss_valid_i = 1'b0;
        miss_addr_i  = $urandom;
        for (int i = 0; i < ar_dly; i++) begin
            check("ar_hold_valid", arvalid_o, 1);
            check("ar_hold_addr", araddr_o, line);
            check("ar_busy", miss_ready_o, 0);
            @(posedge clk);
            @(negedge clk);
        end
        check("ar_valid", arvalid_o, 1);
        check("ar_addr", araddr_o, line);
        check("ar_busy", miss_ready_o, 0);
        arready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        arready_i = 1'b0;
        check("r_arvalid_low", arvalid_o, 0);
    endtask

    task automatic run_txn(input logic [AW-1:0] a, input int ar_dly, input int af_cyc,
                           input logic [1:0] rr, input logic rl, input logic [DW-1:0] rd);
        logic [AW-1:0] line;
        logic          e;
        int            start_cnt;
        line = (a >> OW) << OW;
        e    = (rr != 2'b00) || !rl;
        start_cnt = wren_cnt;
        issue_miss(a, ar_dly);
        rvalid_i = 1'b1;
        rdata_i  = rd;
        rresp_i  = rr;
        rlast_i  = rl;
        for (int i = 0; i < af_cyc; i++) begin
            afull_i = 1'b1;
            #1;
            check("stall_rready", rready_o, 0);
            check("stall_no_resp", resp_valid_o, 0);
            @(posedge clk);
            @(negedge clk);
        end
        afull_i = 1'b0;
        #1;
        check("r_rready", rready_o, 1);
        check("r_no_wren", wren_o, 0);
        @(posedge clk);
        @(negedge clk);
        rvalid_i = 1'b0;
        rdata_i  = {$urandom, $urandom};
        rlast_i  = 1'b1;
        rresp_i  = 2'b00;
        check("done_resp_valid", resp_valid_o, 1);
        check("done_resp_err", resp_err_o, e);
        check("done_wren", wren_o, !e);
        check("done_busy", miss_ready_o, 0);
        if (!e) check("done_data", data_o, {line, rd});
        @(posedge clk);
        @(negedge clk);
        check("after_resp_valid", resp_valid_o, 0);
        check("after_wren", wren_o, 0);
        check("after_ready", miss_ready_o, 1);
        check("wren_count", wren_cnt - start_cnt, e ? 0 : 1);
    endtask

    initial begin
        int base;
        #2;
        check_reset_outputs("reset");
        check("arid", arid_o, TB_ID);
        check("arlen", arlen_o, 0);
        check("arsize", arsize_o, 3);
        check("arburst", arburst_o, 2'b01);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'h0000_1234, 0, 0, 2'b00, 1'b1, {8{8'hA5}});
        run_txn(32'h0000_4321, 0, 5, 2'b00, 1'b1, 64'h0123_4567_89AB_CDEF);
        run_txn(32'hDEAD_BEEF, 4, 0, 2'b00, 1'b1, 64'hFEED_FACE_CAFE_F00D);
        run_txn(32'h0000_0A00, 0, 0, 2'b10, 1'b1, 64'h1111_2222_3333_4444);
        run_txn(32'h0000_0BFF, 1, 1, 2'b00, 1'b0, 64'h5555_6666_7777_8888);

        // Asynchronous reset while waiting on R abandons the transaction.
        base = wren_cnt;
        issue_miss(32'h0001_0FF0, 0);
        #1;
        check("pre_reset_rready", rready_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        rvalid_i = 1'b1;
        rdata_i  = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("post_reset_no_resp", resp_valid_o, 0);
        end
        rvalid_i = 1'b0;
        check("post_reset_no_wren", wren_cnt - base, 0);
        run_txn(32'h0002_0345, 0, 0, 2'b00, 1'b1, 64'h0BAD_C0DE_1234_5678);

        for (int n = 0; n < 20; n++) begin
            logic [1:0] rr;
            logic       rl;
            rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            rl = ($urandom_range(0, 4) != 0);
            run_txn($urandom, $urandom_range(0, 3), $urandom_range(0, 3), rr, rl,
                    {$urandom, $urandom});
        end

`ifdef MISS_REFILL_TIMEOUT_EN
        base = wren_cnt;
        issue_miss(32'h0003_3333, 0);
        for (int k = 0; k < TO; k++) begin
            check("to_wait_no_resp", resp_valid_o, 0);
            @(posedge clk);
            @(negedge clk);
        end
        check("to_resp_valid", resp_valid_o, 1);
        check("to_resp_err", resp_err_o, 1);
        check("to_wren", wren_o, 0);
        @(posedge clk);
        @(negedge clk);
        rvalid_i = 1'b1;
        rdata_i  = {$urandom, $urandom};
        #1;
        check("stray_rready", rready_o, 1);
        @(posedge clk);
        @(negedge clk);
        rvalid_i = 1'b0;
        check("stray_no_resp", resp_valid_o, 0);
        check("stray_ready", miss_ready_o, 1);
        check("stray_no_wren", wren_cnt - base, 0);
        run_txn(32'h0004_0040, 0, 0, 2'b00, 1'b1, 64'h7777_0000_7777_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
